multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-FSM control unit for the multicycle MIPS datapath. Successor to the single-cycle combinational decoder.
- Sequences fetch, decode, execute, memory and writeback over several cycles, so one ALU and one unified memory are shared.
- Adds a memory-ready handshake, illegal-instruction detection, a parametrised ALU-control width and an optional multi-cycle multiply.

Parameters:
- ALU_CTRL_W, 3: width of ALUcontrol. Must be >=3; the code occupies bits [2:0] and upper bits are driven 0.
- MUL_LATENCY, 4: number of MULEX cycles when MUL_EN is defined. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  instruction[31:26], taken from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA  out  1 each  datapath controls
- ALUsrcB  out  2  00 = regB, 01 = const 4, 10 = signimm, 11 = signimm<<2
- ALUcontrol  out  ALU_CTRL_W  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 mul
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite, Branch, jmp  out  1 each
- PCEn  out  1  PCWrite | (Branch & zero)
- illegal  out  1  one-cycle pulse on an undecodable instruction
- state  out  4  current state code, for debug

Behaviour:
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, MULEX 12.
- State register updates on the rising edge of clk.
- All outputs except illegal are combinational decodes of the registered state, plus mem_ready/zero where noted. Unlisted outputs are 0.
- Reset: rst=1 at an edge forces state=FETCH and clears the mul counter. This applies mid-instruction, including during a memory wait or MULEX.
- While rst=1: IRWrite, PCWrite, PCEn, MemWrite, RegWrite and illegal are forced 0. The remaining outputs take their FETCH values.
- FETCH: IorD=0, ALUsrcA=0, ALUsrcB=01, ALUcontrol=add, PCSrc=00. IRWrite=PCWrite=mem_ready. Hold while mem_ready=0; go to DECODE when 1.
- DECODE: ALUsrcA=0, ALUsrcB=11, ALUcontrol=add. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 001000 -> ADDIEX
  - 000100 -> BRANCH
  - 000010 -> JUMP
- DECODE, R-type legality: opcode 000000 requires funct in {100000, 100010, 100100, 100101, 101010}, or 011000 when MUL_EN is defined.
- DECODE, illegal case: any other opcode or funct registers illegal=1 for exactly the next cycle and returns to FETCH. PC is already incremented, so the instruction is skipped.
- MEMADR: ALUsrcA=1, ALUsrcB=10, add. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Hold until mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Then FETCH.
- MEMWR: IorD=1, MemWrite=1 in every cycle of the state. Hold until mem_ready, then FETCH.
- EXECUTE: ALUsrcA=1, ALUsrcB=00. ALUcontrol by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Funct 011000 goes to MULEX; all others go to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Then FETCH.
- ADDIEX: ALUsrcA=1, ALUsrcB=10, add; then ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; then FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, sub, Branch=1, PCSrc=01. PCEn=zero. Then FETCH.
- JUMP: PCSrc=10, PCWrite=1, jmp=1. Then FETCH.
- Instruction latency with mem_ready=1 throughout:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - each memory-wait cycle adds 1.

Optional Feature:
- MUL_EN defined:
  - funct 011000 is legal.
  - EXECUTE -> MULEX. MULEX drives ALUsrcA=1, ALUsrcB=00, ALUcontrol=011 and has RegWrite=0.
  - A 4-bit counter clears on entry and increments each MULEX cycle. Exit to ALUWB after exactly MUL_LATENCY cycles in MULEX.
- MUL_EN undefined: funct 011000 is illegal. MULEX and the counter are not synthesised; state code 12 is unreachable.

Test Plan:
- Reset: rst=1 for 2 cycles during MEMRD wait -> state=0; IRWrite, PCWrite, MemWrite, RegWrite all 0. First cycle after rst=0 with mem_ready=1 -> IRWrite=1, PCWrite=1.
- lw (opcode 100011), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- R-type sub (000000/100010) -> states 0,1,6,7. ALUcontrol=110 in state 6; RegDst=1 and RegWrite=1 in state 7.
- beq (000100): zero=1 -> PCEn=1 in state 8. Repeat with zero=0 -> PCEn=0. j (000010) -> PCSrc=10, PCEn=1 in state 11.
- Illegal opcode 011010, then opcode 000000 with funct 011100 -> each gives state 0,1,0 with illegal=1 for exactly one cycle after DECODE; RegWrite and MemWrite never 1.
- MUL_EN defined, MUL_LATENCY=4, funct 011000 -> state 12 for exactly 4 cycles with ALUcontrol=011, then 7 with RegWrite=1. Without MUL_EN -> illegal pulse.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the shared-ALU multicycle MIPS datapath; define MUL_EN to add the multi-cycle multiply state.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W  = 3,
  parameter int MUL_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegDst,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  ALUsrcA,
  output logic [1:0]            ALUsrcB,
  output logic [ALU_CTRL_W-1:0] ALUcontrol,
  output logic [1:0]            PCSrc,
  output logic                  PCWrite,
  output logic                  Branch,
  output logic                  jmp,
  output logic                  PCEn,
  output logic                  illegal,
  output logic [3:0]            state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
    ADDIWB = 4'd10, JUMP = 4'd11, MULEX = 4'd12
  } stateType;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010, F_MUL = 6'b011000;
  if (ALU_CTRL_W < 3 || MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_badParam
    $error("multicycle_control_unit: parameter out of range");
  end
  stateType curState, nextState, s;
  logic illegalQ, illegalNext, rLegal;
  logic [2:0] aluCode;
`ifdef MUL_EN
  logic [3:0] mulCnt;
  logic mulDone;
  assign rLegal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MUL};
  assign mulDone = mulCnt == 4'(MUL_LATENCY - 1);
  always_ff @(posedge clk) mulCnt <= (rst || curState != MULEX) ? 4'd0 : mulCnt + 4'd1;
`else
  assign rLegal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
`endif
  always_ff @(posedge clk) begin
    curState <= rst ? FETCH : nextState;
    illegalQ <= illegalNext;
  end
  // Reset presents the FETCH decode; write-type strobes are then masked.
  always_comb begin
    s = rst ? FETCH : curState;
    nextState = FETCH;
    illegalNext = 1'b0;
    IorD = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUsrcA = 1'b0;
    ALUsrcB = 2'b00;
    aluCode = 3'b010;
    PCSrc = 2'b00;
    PCWrite = 1'b0;
    Branch = 1'b0;
    jmp = 1'b0;
    case (s)
      FETCH: begin
        ALUsrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nextState = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUsrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = rLegal ? EXECUTE : FETCH;
          OP_ADDI:      nextState = ADDIEX;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          default:      nextState = FETCH;
        endcase
        illegalNext = nextState == FETCH;
      end
      MEMADR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        nextState = opcode == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD = 1'b1;
        nextState = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD = 1'b1;
        MemWrite = 1'b1;
        nextState = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUsrcA = 1'b1;
        aluCode = funct == F_SUB ? 3'b110 : funct == F_AND ? 3'b000 :
                  funct == F_OR  ? 3'b001 : funct == F_SLT ? 3'b111 : 3'b010;
`ifdef MUL_EN
        nextState = funct == F_MUL ? MULEX : ALUWB;
`else
        nextState = ALUWB;
`endif
      end
      ALUWB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUsrcA = 1'b1;
        aluCode = 3'b110;
        Branch = 1'b1;
        PCSrc = 2'b01;
      end
      ADDIEX: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        nextState = ADDIWB;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        PCWrite = 1'b1;
        jmp = 1'b1;
      end
`ifdef MUL_EN
      MULEX: begin
        ALUsrcA = 1'b1;
        aluCode = 3'b011;
        nextState = mulDone ? ALUWB : MULEX;
      end
`endif
      default: nextState = FETCH;
    endcase
    if (rst) begin
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end
  assign ALUcontrol = ALU_CTRL_W'(aluCode);
  assign PCEn = PCWrite | (Branch & zero);
  assign illegal = illegalQ & ~rst;
  assign state = curState;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed checks of the multicycle control FSM state sequences and output decodes.
module tb_multicycle_control_unit;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'b0, funct = 6'b0;
  logic IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCWrite, Branch, jmp, PCEn, illegal;
  logic [1:0] ALUsrcB, PCSrc;
  logic [2:0] ALUcontrol;
  logic [3:0] state;
  int nChecks = 0, nPass = 0;
  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUcontrol(ALUcontrol),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch), .jmp(jmp), .PCEn(PCEn),
    .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    check("rst_state", 32'(state), 0);
    check("rst_irwrite", 32'(IRWrite), 0);
    check("rst_pcwrite", 32'(PCWrite), 0);
    check("rst_pcen", 32'(PCEn), 0);
    rst = 1'b0;
    opcode = 6'b100011;
    #1;
    check("fetch_irwrite", 32'(IRWrite), 1);
    check("fetch_pcwrite", 32'(PCWrite), 1);
    check("fetch_pcen", 32'(PCEn), 1);
    check("fetch_srcb", 32'(ALUsrcB), 1);
    check("fetch_alu", 32'(ALUcontrol), 3'b010);
    step();
    check("lw_s1", 32'(state), 1);
    check("dec_srcb", 32'(ALUsrcB), 3);
    step();
    check("lw_s2", 32'(state), 2);
    check("memadr_srcb", 32'(ALUsrcB), 2);
    check("memadr_srca", 32'(ALUsrcA), 1);
    mem_ready = 1'b0;
    step();
    check("lw_s3a", 32'(state), 3);
    check("memrd_iord", 32'(IorD), 1);
    check("memrd_regwrite", 32'(RegWrite), 0);
    step();
    check("lw_s3b", 32'(state), 3);
    step();
    check("lw_s3c", 32'(state), 3);
    mem_ready = 1'b1;
    step();
    check("lw_s4", 32'(state), 4);
    check("memwb_regwrite", 32'(RegWrite), 1);
    check("memwb_memtoreg", 32'(MemtoReg), 1);
    step();
    check("lw_s0", 32'(state), 0);
    check("fetch_memtoreg", 32'(MemtoReg), 0);
    opcode = 6'b101011;
    step();
    step();
    mem_ready = 1'b0;
    step();
    check("sw_s5", 32'(state), 5);
    check("memwr_memwrite", 32'(MemWrite), 1);
    check("memwr_iord", 32'(IorD), 1);
    step();
    check("sw_hold", 32'(state), 5);
    rst = 1'b1;
    #1;
    check("rstmid_memwrite", 32'(MemWrite), 0);
    check("rstmid_iord", 32'(IorD), 0);
    check("rstmid_srcb", 32'(ALUsrcB), 1);
    step();
    step();
    check("rstmid_state", 32'(state), 0);
    check("rstmid_regwrite", 32'(RegWrite), 0);
    rst = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b000000;
    funct = 6'b100010;
    #1;
    check("rstrel_irwrite", 32'(IRWrite), 1);
    step();
    step();
    check("sub_s6", 32'(state), 6);
    check("sub_alu", 32'(ALUcontrol), 3'b110);
    check("exec_srcb", 32'(ALUsrcB), 0);
    step();
    check("sub_s7", 32'(state), 7);
    check("aluwb_regdst", 32'(RegDst), 1);
    check("aluwb_regwrite", 32'(RegWrite), 1);
    step();
    funct = 6'b101010;
    step();
    step();
    check("slt_alu", 32'(ALUcontrol), 3'b111);
    step();
    step();
    opcode = 6'b000100;
    zero = 1'b1;
    step();
    step();
    check("beq_s8", 32'(state), 8);
    check("beq_pcen_z1", 32'(PCEn), 1);
    check("beq_pcsrc", 32'(PCSrc), 1);
    check("beq_alu", 32'(ALUcontrol), 3'b110);
    zero = 1'b0;
    #1;
    check("beq_pcen_z0", 32'(PCEn), 0);
    step();
    check("beq_s0", 32'(state), 0);
    opcode = 6'b000010;
    step();
    step();
    check("j_s11", 32'(state), 11);
    check("j_pcsrc", 32'(PCSrc), 2);
    check("j_pcen", 32'(PCEn), 1);
    check("j_jmp", 32'(jmp), 1);
    step();
    opcode = 6'b001000;
    step();
    step();
    check("addi_s9", 32'(state), 9);
    check("addiex_srcb", 32'(ALUsrcB), 2);
    step();
    check("addi_s10", 32'(state), 10);
    check("addiwb_regwrite", 32'(RegWrite), 1);
    check("addiwb_regdst", 32'(RegDst), 0);
    step();
    opcode = 6'b011010;
    step();
    check("ill_s1", 32'(state), 1);
    check("ill_before", 32'(illegal), 0);
    step();
    check("ill_s0", 32'(state), 0);
    check("ill_pulse", 32'(illegal), 1);
    check("ill_regwrite", 32'(RegWrite), 0);
    check("ill_memwrite", 32'(MemWrite), 0);
    opcode = 6'b000000;
    funct = 6'b011100;
    step();
    check("ill_clear", 32'(illegal), 0);
    check("illf_s1", 32'(state), 1);
    step();
    check("illf_s0", 32'(state), 0);
    check("illf_pulse", 32'(illegal), 1);
    step();
    check("illf_clear", 32'(illegal), 0);
    funct = 6'b011000;
`ifdef MUL_EN
    step();
    check("mul_s6", 32'(state), 6);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mul_s12", 32'(state), 12);
      check("mul_alu", 32'(ALUcontrol), 3'b011);
      check("mul_regwrite", 32'(RegWrite), 0);
    end
    step();
    check("mul_s7", 32'(state), 7);
    check("mul_wb", 32'(RegWrite), 1);
`else
    step();
    check("mul_ill_s0", 32'(state), 0);
    check("mul_ill_pulse", 32'(illegal), 1);
`endif
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
